// File: rtl/uart_rx_if.sv
// Serial-line and consumer-side signals of the UART receiver.
// The slave modport is the receiver; the master modport is the line driver / consumer.
interface uart_rx_if;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;

    modport slave (
        input  RX,
        input  clr_rdy,
        output rx_data,
        output rdy,
        output frm_err
    );

    modport master (
        output RX,
        output clr_rdy,
        input  rx_data,
        input  rdy,
        input  frm_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with start-bit glitch rejection,
// sticky ready flag with consumer acknowledge, and framing-error flag.
module uart_rx #(
    parameter int BAUD_DIV = 2604
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } state_t;

    localparam logic [11:0] HALF_BIT = 12'(BAUD_DIV / 2);
    localparam logic [11:0] FULL_BIT = 12'(BAUD_DIV - 1);

    state_t      state_q, state_d;
    logic [1:0]  sync_q;
    logic [8:0]  shift_q, shift_d;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        frm_err_q, frm_err_d;
    logic        rx_s;

    assign rx_s        = sync_q[1];
    assign bus.rx_data = rx_data_q;
    assign bus.rdy     = rdy_q;
    assign bus.frm_err = frm_err_q;

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.RX};
        end
    end

    // Receiver state, counters, shift register and output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= 9'h1FF;
            baud_cnt_q <= 12'd0;
            bit_cnt_q  <= 4'd0;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            frm_err_q  <= frm_err_d;
        end
    end

    // Next-state logic: start detect, bit sampling and frame completion.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        rx_data_d  = rx_data_q;
        frm_err_d  = frm_err_q;

        // Acknowledge is applied first so a same-cycle frame-end set overrides it.
        if (bus.clr_rdy) begin
            rdy_d = 1'b0;
        end else begin
            rdy_d = rdy_q;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = RECEIVE;
                    baud_cnt_d = HALF_BIT;
                    bit_cnt_d  = 4'd0;
                    rdy_d      = 1'b0;
                    frm_err_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RECEIVE: begin
                if (baud_cnt_q == 12'd0) begin
                    shift_d    = {rx_s, shift_q[8:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    baud_cnt_d = FULL_BIT;
                    if ((bit_cnt_q == 4'd0) && rx_s) begin
                        state_d = IDLE;
                    end else if (bit_cnt_q == 4'd9) begin
                        state_d = IDLE;
                        // shift_q[0] holds the start sample here; it is re-confirmed low.
                        if (rx_s && !shift_q[0]) begin
                            rx_data_d = shift_q[8:1];
                            rdy_d     = 1'b1;
                            frm_err_d = 1'b0;
                        end else begin
                            frm_err_d = 1'b1;
                        end
                    end else begin
                        state_d = RECEIVE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 SHALL have parameter BAUD_DIV, default 2604, clocks per bit (50 MHz / 19200 baud).
- REQ-002 SHALL have port clk, input, 1, system clock, all flops rising-edge.
- REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
- REQ-004 SHALL have port RX, input, 1, asynchronous serial line, idle high, 8N1 LSB-first.
- REQ-005 SHALL have port clr_rdy, input, 1, consumer acknowledge, clears rdy.
- REQ-006 SHALL have port rx_data, output, 8, last received byte.
- REQ-007 SHALL have port rdy, output, 1, set/reset flag, high when rx_data holds an unconsumed valid byte.
- REQ-008 SHALL have port frm_err, output, 1, set/reset flag, high when the last frame had stop bit = 0.

Function
- REQ-009 SHALL pass RX through a two-flop synchronizer, both flops reset to 1; all logic uses only the synchronized value rx_s.
- REQ-010 SHALL implement two states: IDLE and RECEIVE.
- REQ-011 SHALL, in IDLE, enter RECEIVE on the first cycle rx_s = 0, loading baud_cnt = BAUD_DIV/2 (1302) and bit_cnt = 0.
- REQ-012 SHALL, in RECEIVE, decrement baud_cnt each cycle; sample = (baud_cnt == 0).
- REQ-013 SHALL, on each sample, shift rx_s into a 9-bit shift register MSB-first (right shift), increment bit_cnt, and reload baud_cnt = BAUD_DIV-1.
- REQ-014 SHALL check the start bit: on the sample with bit_cnt = 0, if rx_s = 1, return to IDLE with no flag change (false start / glitch rejection).
- REQ-015 SHALL end the frame on the 10th sample (start, 8 data, stop), returning to IDLE in the same cycle bit_cnt reaches 10.
- REQ-016 SHALL, at frame end with stop = 1, load rx_data from shift register bits [7:0] (data bits, LSB first on line), set rdy, and clear frm_err.
- REQ-017 SHALL, at frame end with stop = 0, leave rx_data and rdy unchanged, and set frm_err.
- REQ-018 SHALL clear rdy on clr_rdy = 1 or on the start-detect cycle of a new frame; a frame-end set in the same cycle as clr_rdy SHALL win (rdy = 1).
- REQ-019 SHALL clear frm_err on the start-detect cycle of a new frame.
- REQ-020 SHALL keep baud_cnt and bit_cnt frozen in IDLE (no toggling).
- REQ-021 SHALL ignore RX activity during RECEIVE other than the scheduled samples.
- REQ-022 SHALL, at the end of a frame whose stop bit is followed immediately by a new start bit, detect that start no later than 1 cycle after returning to IDLE.
- REQ-023 SHALL assert rdy (latency) 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles ±1 after the RX falling edge.
- REQ-024 SHALL keep baud_cnt 12 bits wide and bit_cnt 4 bits wide.

Reset
- REQ-025 SHALL, while rst_n = 0, force state = IDLE, synchronizer = 2'b11, shift register = 9'h1FF, baud_cnt = 0, bit_cnt = 0, rx_data = 8'h00, rdy = 0, frm_err = 0.
- REQ-026 SHALL, when reset is asserted mid-frame, discard the partial frame and not assert rdy until a complete new frame is received.

Verification
- REQ-027 SHALL pass this scenario: loopback from uart_tx sending 8'hA5 -> rdy rises once, rx_data = 8'hA5, frm_err = 0; repeat for 8'h00, 8'hFF, 8'h01, 8'h80.
- REQ-028 SHALL pass this scenario: send 8'h3C, hold clr_rdy low, then pulse clr_rdy for 1 cycle -> rdy stays high until the pulse, low the next cycle; rx_data holds 8'h3C.
- REQ-029 SHALL pass this scenario: RX low pulse of 500 cycles (< BAUD_DIV/2) -> return to IDLE, rdy = 0, frm_err = 0, rx_data unchanged.
- REQ-030 SHALL pass this scenario: frame 8'h55 with stop bit driven 0 -> frm_err = 1, rdy = 0, rx_data unchanged; next valid frame 8'h12 -> frm_err = 0, rdy = 1, rx_data = 8'h12.
- REQ-031 SHALL pass this scenario: back-to-back frames 8'hDE, 8'hAD with zero idle gap, clr_rdy pulsed after each -> two rdy pulses with correct data; plus the case where clr_rdy coincides with frame end, where rdy stays 1.
- REQ-032 SHALL pass this scenario: rst_n asserted during bit 4 of 8'hC3 then released, RX held high -> all outputs at reset values, no rdy; next frame 8'h7E received correctly.
